// File: rtl/seq_pkg.sv
// -----------------------------------------------------------------------------
// seq_pkg
// Shared constants and types for the sequence-match arbiter:
//   - FSM state encoding (S_IDLE, S_FEED, S_REPORT)
//   - symbol / frame / sum widths
//   - the default 0,6,4,2 pattern
//   - FAIL_NONE, the first-mismatch index that means "every symbol matched"
// -----------------------------------------------------------------------------
package seq_pkg;

  localparam int SYM_W   = 3;
  localparam int NSYM    = 4;
  localparam int FRAME_W = NSYM * SYM_W;
  localparam int SUM_W   = 5;

  localparam logic [SYM_W-1:0] PAT0 = 3'd0;
  localparam logic [SYM_W-1:0] PAT1 = 3'd6;
  localparam logic [SYM_W-1:0] PAT2 = 3'd4;
  localparam logic [SYM_W-1:0] PAT3 = 3'd2;

  // One past the last symbol index: no mismatch was seen.
  localparam logic [2:0] FAIL_NONE = 3'd4;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FEED   = 2'd1,
    S_REPORT = 2'd2
  } state_t;

endpackage

// File: rtl/seq_match_core.sv
// -----------------------------------------------------------------------------
// seq_match_core
// Running-sum and first-mismatch datapath. One symbol is presented per cycle
// while sym_valid is high; idx says which pattern position it belongs to.
//
// The sum/fail_idx outputs are the running results *including* the symbol
// currently presented, so the caller can register the final result on the
// same edge that consumes the last symbol.
//
// Ports
//   clk        in   clock
//   rst        in   asynchronous active-low reset
//   clear      in   start a new frame: sum=0, fail_idx=FAIL_NONE
//   sym_valid  in   sym/idx carry a symbol this cycle
//   idx        in   position 0..3 of the presented symbol
//   sym        in   presented symbol
//   sum        out  running sum including the presented symbol
//   fail_idx   out  first mismatching position so far, FAIL_NONE if none
// -----------------------------------------------------------------------------
module seq_match_core
  import seq_pkg::SUM_W;
  import seq_pkg::FAIL_NONE;
#(
  parameter int               SYM_W = seq_pkg::SYM_W,
  parameter logic [SYM_W-1:0] PAT0  = seq_pkg::PAT0,
  parameter logic [SYM_W-1:0] PAT1  = seq_pkg::PAT1,
  parameter logic [SYM_W-1:0] PAT2  = seq_pkg::PAT2,
  parameter logic [SYM_W-1:0] PAT3  = seq_pkg::PAT3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             sym_valid,
  input  logic [1:0]       idx,
  input  logic [SYM_W-1:0] sym,
  output logic [SUM_W-1:0] sum,
  output logic [2:0]       fail_idx
);

  logic [SUM_W-1:0] acc_q;
  logic [2:0]       fail_q;
  logic [SYM_W-1:0] exp_sym;

  always_comb begin
    unique case (idx)
      2'd0:    exp_sym = PAT0;
      2'd1:    exp_sym = PAT1;
      2'd2:    exp_sym = PAT2;
      default: exp_sym = PAT3;
    endcase
  end

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so
    // no path leaves it unassigned and no latch is inferred.
    sum      = acc_q;
    fail_idx = fail_q;
    if (sym_valid) begin
      sum = acc_q + SUM_W'(sym);
      // Only the first mismatch is remembered.
      if ((sym != exp_sym) && (fail_q == FAIL_NONE)) begin
        fail_idx = {1'b0, idx};
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q  <= '0;
      fail_q <= '0;
    end else if (clear) begin
      acc_q  <= '0;
      fail_q <= FAIL_NONE;
    end else if (sym_valid) begin
      // NOTE: sequential state is updated with non-blocking assignments so
      // every register samples pre-edge values regardless of statement order.
      acc_q  <= sum;
      fail_q <= fail_idx;
    end
  end

endmodule

// File: rtl/seq_match_arbiter.sv
// -----------------------------------------------------------------------------
// seq_match_arbiter
// Round-robin front end that shares one seq_match_core among NREQ requesters.
// In IDLE the first requesting index at or after rr_ptr (with wrap) is
// granted, its 4-symbol frame captured, and the symbols are fed to the core
// over four FEED cycles. REPORT presents the tagged result for one cycle.
// Service period for back-to-back requests is 6 cycles.
//
// Ports
//   clk           in   clock, all state on rising edge
//   rst           in   asynchronous active-low reset
//   req           in   per-requester request level
//   frame         in   frames; symbol k of requester r at [r*4*SYM_W + k*SYM_W +: SYM_W]
//   gnt           out  one-hot grant, 1-cycle pulse after the accept edge
//   busy          out  high whenever the FSM is not in IDLE
//   rsp_valid     out  1-cycle response strobe (REPORT state)
//   rsp_id        out  requester that was served
//   rsp_match     out  all four symbols matched the pattern
//   rsp_sum       out  sum of the four symbols
//   rsp_fail_idx  out  first mismatching index, 4 on full match
// -----------------------------------------------------------------------------
module seq_match_arbiter
  import seq_pkg::state_t;
  import seq_pkg::S_IDLE;
  import seq_pkg::S_FEED;
  import seq_pkg::S_REPORT;
  import seq_pkg::SUM_W;
  import seq_pkg::FAIL_NONE;
#(
  parameter int               NREQ  = 4,
  parameter int               SYM_W = seq_pkg::SYM_W,
  parameter logic [SYM_W-1:0] PAT0  = seq_pkg::PAT0,
  parameter logic [SYM_W-1:0] PAT1  = seq_pkg::PAT1,
  parameter logic [SYM_W-1:0] PAT2  = seq_pkg::PAT2,
  parameter logic [SYM_W-1:0] PAT3  = seq_pkg::PAT3,
  localparam int              ID_W  = (NREQ > 1) ? $clog2(NREQ) : 1,
  localparam int              FW    = 4 * SYM_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*FW-1:0]   frame,
  output logic [NREQ-1:0]      gnt,
  output logic                 busy,
  output logic                 rsp_valid,
  output logic [ID_W-1:0]      rsp_id,
  output logic                 rsp_match,
  output logic [SUM_W-1:0]     rsp_sum,
  output logic [2:0]           rsp_fail_idx
);

  state_t          state;
  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] cur_id;
  logic [FW-1:0]   frame_q;
  logic [1:0]      idx;

  logic            found;
  logic [ID_W-1:0] sel;

  logic            core_clear;
  logic            core_valid;
  logic [SYM_W-1:0] core_sym;
  logic [SUM_W-1:0] core_sum;
  logic [2:0]      core_fail;

  // (base + off) mod NREQ for off < NREQ.
  function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] base,
                                               input int unsigned     off);
    int unsigned s;
    s = 32'(base) + off;
    if (s >= 32'(NREQ)) s = s - 32'(NREQ);
    return s[ID_W-1:0];
  endfunction

  // Round-robin search starting at rr_ptr; the first hit wins.
  always_comb begin
    found = 1'b0;
    sel   = rr_ptr;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (!found && req[wrap_add(rr_ptr, i)]) begin
        found = 1'b1;
        sel   = wrap_add(rr_ptr, i);
      end
    end
  end

  assign core_clear = (state == S_IDLE) && found;
  assign core_valid = (state == S_FEED);
  assign core_sym   = frame_q[idx*SYM_W +: SYM_W];
  assign busy       = (state != S_IDLE);

  seq_match_core #(
    .SYM_W (SYM_W),
    .PAT0  (PAT0),
    .PAT1  (PAT1),
    .PAT2  (PAT2),
    .PAT3  (PAT3)
  ) u_core (
    .clk       (clk),
    .rst       (rst),
    .clear     (core_clear),
    .sym_valid (core_valid),
    .idx       (idx),
    .sym       (core_sym),
    .sum       (core_sum),
    .fail_idx  (core_fail)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= S_IDLE;
      rr_ptr       <= '0;
      cur_id       <= '0;
      idx          <= '0;
      // NOTE: the captured frame is a plain register, not a memory array,
      // so clearing it on reset is cheap and keeps the datapath deterministic.
      frame_q      <= '0;
      gnt          <= '0;
      rsp_valid    <= 1'b0;
      rsp_id       <= '0;
      rsp_match    <= 1'b0;
      rsp_sum      <= '0;
      rsp_fail_idx <= '0;
    end else begin
      gnt       <= '0;
      rsp_valid <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (found) begin
            frame_q <= frame[sel*FW +: FW];
            gnt     <= NREQ'(1) << sel;
            rr_ptr  <= wrap_add(sel, 1);
            cur_id  <= sel;
            idx     <= 2'd0;
            state   <= S_FEED;
          end
        end
        S_FEED: begin
          idx <= idx + 2'd1;
          if (idx == 2'd3) begin
            // Core outputs already include the last symbol, so the result
            // is registered here and is valid throughout REPORT.
            state        <= S_REPORT;
            rsp_valid    <= 1'b1;
            rsp_id       <= cur_id;
            rsp_sum      <= core_sum;
            rsp_fail_idx <= core_fail;
            rsp_match    <= (core_fail == FAIL_NONE);
          end
        end
        S_REPORT: state <= S_IDLE;
        default:  state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_match_arbiter.sv
// -----------------------------------------------------------------------------
// tb_seq_match_arbiter
// Directed and randomized sessions against a behavioural reference: the
// expected grant comes from a modulo round-robin search over the request
// mask, and the expected result from summing the frame and scanning for the
// first symbol that differs from the 0,6,4,2 pattern.
// -----------------------------------------------------------------------------
module tb_seq_match_arbiter;

  localparam int NREQ = 4;
  localparam int FW   = 12;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req;
  logic [NREQ*FW-1:0] frame;
  logic [NREQ-1:0]   gnt;
  logic              busy;
  logic              rsp_valid;
  logic [1:0]        rsp_id;
  logic              rsp_match;
  logic [4:0]        rsp_sum;
  logic [2:0]        rsp_fail_idx;

  int checks   = 0;
  int failures = 0;
  int rr_model = 0;

  logic [2:0] pat [4] = '{3'd0, 3'd6, 3'd4, 3'd2};

  seq_match_arbiter #(.NREQ(NREQ)) dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .frame        (frame),
    .gnt          (gnt),
    .busy         (busy),
    .rsp_valid    (rsp_valid),
    .rsp_id       (rsp_id),
    .rsp_match    (rsp_match),
    .rsp_sum      (rsp_sum),
    .rsp_fail_idx (rsp_fail_idx)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference arbitration: first set bit at or after ptr, modulo NREQ.
  function automatic int pick(input logic [NREQ-1:0] r, input int ptr);
    for (int k = 0; k < NREQ; k++) begin
      if (r[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
    end
    return 0;
  endfunction

  // Reference result: plain sum plus first index that differs from the pattern.
  task automatic expect_of(input logic [11:0] f, output int esum, output int efail);
    logic [2:0] s;
    esum  = 0;
    efail = 4;
    for (int k = 0; k < 4; k++) begin
      s    = f[k*3 +: 3];
      esum = esum + int'(s);
      if (efail == 4 && s != pat[k]) efail = k;
    end
  endtask

  task automatic set_frame(input int r, input logic [2:0] s0, input logic [2:0] s1,
                           input logic [2:0] s2, input logic [2:0] s3);
    frame[r*FW +: FW] = {s3, s2, s1, s0};
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".gnt"},      32'(gnt),          0);
    check({tag, ".busy"},     32'(busy),         0);
    check({tag, ".valid"},    32'(rsp_valid),    0);
    check({tag, ".id"},       32'(rsp_id),       0);
    check({tag, ".match"},    32'(rsp_match),    0);
    check({tag, ".sum"},      32'(rsp_sum),      0);
    check({tag, ".fail_idx"}, 32'(rsp_fail_idx), 0);
  endtask

  task automatic scramble_inputs();
    req   = NREQ'($urandom);
    frame = {$urandom, $urandom};
  endtask

  // Called at the negedge before an accept edge with req/frame driven.
  // Returns at the negedge of the following IDLE cycle.
  task automatic session(input string tag, input logic [NREQ-1:0] drop_mask,
                         input bit scramble);
    int id, esum, efail;
    logic [11:0] f;
    id = pick(req, rr_model);
    f  = frame[id*FW +: FW];
    expect_of(f, esum, efail);
    rr_model = (id + 1) % NREQ;

    @(negedge clk);
    check({tag, ".gnt"},   32'(gnt),       32'(1) << id);
    check({tag, ".busy"},  32'(busy),      1);
    check({tag, ".valid"}, 32'(rsp_valid), 0);
    req = req & ~drop_mask;

    for (int c = 0; c < 3; c++) begin
      if (scramble) scramble_inputs();
      @(negedge clk);
      check({tag, ".feed_gnt"},   32'(gnt),       0);
      check({tag, ".feed_valid"}, 32'(rsp_valid), 0);
      check({tag, ".feed_busy"},  32'(busy),      1);
    end
    if (scramble) scramble_inputs();

    @(negedge clk);
    check({tag, ".rsp_valid"}, 32'(rsp_valid),    1);
    check({tag, ".rsp_gnt"},   32'(gnt),          0);
    check({tag, ".rsp_id"},    32'(rsp_id),       32'(id));
    check({tag, ".rsp_match"}, 32'(rsp_match),    32'(efail == 4));
    check({tag, ".rsp_sum"},   32'(rsp_sum),      32'(esum));
    check({tag, ".rsp_fail"},  32'(rsp_fail_idx), 32'(efail));

    @(negedge clk);
    check({tag, ".idle_valid"}, 32'(rsp_valid), 0);
    check({tag, ".idle_busy"},  32'(busy),      0);
    check({tag, ".idle_gnt"},   32'(gnt),       0);
    check({tag, ".hold_sum"},   32'(rsp_sum),   32'(esum));
  endtask

  task automatic random_frames();
    logic [11:0] f;
    for (int r = 0; r < NREQ; r++) begin
      if ($urandom_range(0, 1) == 1) begin
        f = {3'd2, 3'd4, 3'd6, 3'd0};
        if ($urandom_range(0, 1) == 1) f[$urandom_range(0, 3)*3 +: 3] = 3'($urandom);
      end else begin
        f = 12'($urandom);
      end
      frame[r*FW +: FW] = f;
    end
  endtask

  initial begin
    rst   = 1'b0;
    req   = '0;
    frame = '0;

    // Reset state
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst      = 1'b1;
    rr_model = 0;
    @(negedge clk);
    check("idle_no_req.busy", 32'(busy), 0);
    check("idle_no_req.gnt",  32'(gnt),  0);

    // 1: exact pattern from requester 0
    set_frame(0, 3'd0, 3'd6, 3'd4, 3'd2);
    req = 4'b0001;
    session("t1", 4'b0001, 1'b0);

    // 2: mismatch at index 2 from requester 1
    set_frame(1, 3'd0, 3'd6, 3'd5, 3'd2);
    req = 4'b0010;
    session("t2", 4'b0010, 1'b0);
    req = '0;
    repeat (2) @(negedge clk);
    check("t2.quiet_busy", 32'(busy), 0);

    // 3: all four held continuously after a fresh reset
    rst = 1'b0;
    #1;
    check_all_zero("t3_reset");
    @(negedge clk);
    rst      = 1'b1;
    rr_model = 0;
    random_frames();
    req = 4'b1111;
    for (int n = 0; n < 4; n++) session("t3", 4'b0000, 1'b0);
    req = '0;

    // 4: after requester 2 is served, 3 beats 0
    req = 4'b0100;
    session("t4a", 4'b0100, 1'b0);
    req = 4'b1001;
    session("t4b", 4'b1000, 1'b0);
    session("t4c", 4'b0001, 1'b0);

    // 5: reset during FEED idx=2 aborts and resets rr_ptr
    req = 4'b0100;
    @(negedge clk);
    check("t5.gnt", 32'(gnt), 32'h4);
    req = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    req = 4'b0011;
    #1;
    check_all_zero("t5_abort");
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      check("t5.reset_valid", 32'(rsp_valid), 0);
    end
    rst      = 1'b1;
    rr_model = 0;
    set_frame(0, 3'd0, 3'd6, 3'd4, 3'd1);
    set_frame(1, 3'd3, 3'd6, 3'd4, 3'd2);
    session("t5a", 4'b0001, 1'b0);
    session("t5b", 4'b0010, 1'b0);

    // 6: sum boundaries
    set_frame(2, 3'd7, 3'd7, 3'd7, 3'd7);
    req = 4'b0100;
    session("t6a", 4'b0100, 1'b0);
    set_frame(1, 3'd0, 3'd0, 3'd0, 3'd0);
    req = 4'b0010;
    session("t6b", 4'b0010, 1'b0);

    // Random sessions; odd iterations scramble req/frame during FEED/REPORT
    for (int n = 0; n < 40; n++) begin
      random_frames();
      req = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      session("rand", NREQ'($urandom), n[0]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seq_match_arbiter.md
Name: seq_match_arbiter

Overview:
- Shares one 4-symbol pattern-match datapath among NREQ requesters.
- Each requester presents a 4-symbol frame of 3-bit symbols. The block arbitrates round-robin, captures the granted frame and feeds it one symbol per cycle through the match core.
- It then returns match, sum and first-mismatch index tagged with the requester id.
- It sits in front of the sequence-detection logic, so several producers can use one checker for the 0,6,4,2 pattern.

Parameters:
- NREQ, 4, number of requesters (2..8).
- SYM_W, 3, symbol width.
- PAT0, 3'd0, expected symbol 0.
- PAT1, 3'd6, expected symbol 1.
- PAT2, 3'd4, expected symbol 2.
- PAT3, 3'd2, expected symbol 3.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- req  in  NREQ  per-requester request level.
- frame  in  NREQ*4*SYM_W  frames; symbol k of requester r is at frame[r*12 + k*3 +: 3].
- gnt  out  NREQ  one-hot grant, registered, 1-cycle pulse.
- busy  out  1  high whenever state is not IDLE.
- rsp_valid  out  1  1-cycle response strobe.
- rsp_id  out  clog2(NREQ)  requester served.
- rsp_match  out  1  all four symbols equal to PAT0..PAT3.
- rsp_sum  out  5  sum of the four symbols, 0..28.
- rsp_fail_idx  out  3  index of the first mismatching symbol, 0..3; value 4 means full match.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; rr_ptr=0; gnt=0; busy=0; rsp_valid=0; rsp_id=0; rsp_match=0; rsp_sum=0; rsp_fail_idx=0; captured frame and accumulators cleared.
- Reset mid-operation aborts the current frame. No rsp_valid is issued for the aborted frame.
- States: IDLE, FEED, REPORT.
- IDLE:
  - If any req bit is set, select the first set bit searching from rr_ptr upward, with wrap.
  - On that edge: capture that requester's frame, set gnt[sel]=1 for one cycle, set rr_ptr=sel+1 mod NREQ, clear sum to 0, set fail_idx=4, set idx=0, go to FEED.
  - If no req bit is set, stay in IDLE.
- FEED, 4 cycles (idx 0..3):
  - Symbol idx goes to the core.
  - sum += symbol, computed 5 bits wide, no overflow possible.
  - If symbol != PATidx and fail_idx==4, then fail_idx=idx.
  - After idx==3, go to REPORT.
- REPORT, 1 cycle:
  - rsp_valid=1.
  - rsp_id, rsp_match (=fail_idx==4), rsp_sum and rsp_fail_idx are registered valid this cycle.
  - Go to IDLE.
- rsp_* data outputs hold their last value until the next REPORT.
- Latency: accept edge → FEED cycles 1-4 → rsp_valid in cycle 5 after the accept edge. Back-to-back service period is 6 cycles (IDLE + 4 FEED + REPORT).
- Handshake:
  - A requester holds req and frame stable until it sees gnt.
  - It may drop req in the gnt cycle.
  - Frame contents after capture are ignored.
  - Dropping req before grant withdraws the request with no side effect.
- req changes during FEED/REPORT are ignored; arbitration happens only in IDLE.
- gnt and rsp_valid are never high in the same cycle.
- Simultaneous requests: exactly one grant per IDLE cycle. Round-robin guarantees each persistent requester is served within NREQ sessions.

Decomposition:
- Package seq_pkg holds:
  - state encoding constants S_IDLE, S_FEED, S_REPORT.
  - SYM_W, FRAME_W=4*SYM_W, SUM_W=5.
  - pattern constants PAT0..PAT3.
  - FAIL_NONE=3'd4.
- Sub-module seq_match_core holds the datapath.
  - Inputs: clk, rst, clear, sym_valid, idx[1:0], sym[2:0].
  - Outputs: sum[4:0], fail_idx[2:0].
  - It owns the accumulator and first-mismatch logic.
- The top level owns the arbiter, FSM, frame capture and symbol mux.

Test Plan:
1. Only req[0] with frame symbols {0,6,4,2} → gnt=4'b0001 one cycle after the accept edge; rsp_valid 5 cycles after accept with rsp_id=0, rsp_match=1, rsp_sum=12, rsp_fail_idx=4.
2. req[1] with {0,6,5,2} → rsp_id=1, rsp_match=0, rsp_sum=13, rsp_fail_idx=2.
3. All four req held continuously → grants in order 0,1,2,3, each spaced 6 cycles; four responses in the same order; no gnt/rsp_valid overlap.
4. After req[2] is served, assert req[0] and req[3] together → req[3] is granted first, then req[0].
5. Assert rst=0 during FEED idx=2 → all outputs are 0 immediately and no rsp_valid follows; after release with req[1] and req[0] both asserted, req[0] is granted first (rr_ptr=0).
6. Frame {7,7,7,7} → rsp_sum=28 with no wrap, rsp_fail_idx=0, rsp_match=0; frame {0,0,0,0} → rsp_sum=0, rsp_fail_idx=1.
